// File: rtl/vector_alu.sv
// Two-stage pipelined lane-parallel integer ALU with N/Z/V/C flags per lane.
// S1 holds the accepted operand bundle; S2 holds the computed result and flags.
module vector_alu #(
  parameter int WIDTH = 16,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               op,
  input  logic [LANES*WIDTH-1:0]   a,
  input  logic [LANES*WIDTH-1:0]   b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   result,
  output logic [LANES-1:0]         n,
  output logic [LANES-1:0]         z,
  output logic [LANES-1:0]         v,
  output logic [LANES-1:0]         c
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_RED = 3'b101;
  localparam logic [2:0] OP_PSA = 3'b110;

  logic                   s1_valid;
  logic [2:0]             s1_op;
  logic [LANES*WIDTH-1:0] s1_a;
  logic [LANES*WIDTH-1:0] s1_b;
  logic                   s2_load;
  logic                   in_xfer;

  logic [LANES*WIDTH-1:0] res_d;
  logic [LANES-1:0]       n_d, z_d, v_d, c_d;
  logic [WIDTH-1:0]       red_sum;
  logic [WIDTH-1:0]       la, lb, lbx, lr;
  logic [WIDTH:0]         sum;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign in_xfer  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_op    <= op;
      s1_a     <= a;
      s1_b     <= b;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_comb begin
    res_d   = '0;
    n_d     = '0;
    z_d     = '0;
    v_d     = '0;
    c_d     = '0;
    red_sum = '0;
    la      = '0;
    lb      = '0;
    lbx     = '0;
    lr      = '0;
    sum     = '0;
    for (int i = 0; i < LANES; i++) begin
      red_sum = red_sum + s1_a[i*WIDTH +: WIDTH];
    end
    for (int i = 0; i < LANES; i++) begin
      la  = s1_a[i*WIDTH +: WIDTH];
      lb  = s1_b[i*WIDTH +: WIDTH];
      // subtract is add of the inverted operand with carry-in, so c means no-borrow
      lbx = (s1_op == OP_SUB) ? ~lb : lb;
      sum = {1'b0, la} + {1'b0, lbx} + {{WIDTH{1'b0}}, (s1_op == OP_SUB)};
      lr  = '0;
      case (s1_op)
        OP_ADD, OP_SUB: begin
          lr     = sum[WIDTH-1:0];
          c_d[i] = sum[WIDTH];
          v_d[i] = (la[WIDTH-1] == lbx[WIDTH-1]) && (lr[WIDTH-1] != la[WIDTH-1]);
        end
        OP_AND:  lr = la & lb;
        OP_OR:   lr = la | lb;
        OP_XOR:  lr = la ^ lb;
        OP_RED:  lr = (i == 0) ? red_sum : '0;
        OP_PSA:  lr = la;
        default: lr = lb;
      endcase
      res_d[i*WIDTH +: WIDTH] = lr;
      n_d[i] = lr[WIDTH-1];
      z_d[i] = (lr == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      n         <= '0;
      z         <= '1;
      v         <= '0;
      c         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      result    <= res_d;
      n         <= n_d;
      z         <= z_d;
      v         <= v_d;
      c         <= c_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vector_alu.sv
// Directed bench for vector_alu (WIDTH=16, LANES=4): vector table plus
// hand-written back-pressure, streaming, flush and reset sequences.
module tb_vector_alu;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  op;
  logic [63:0] a, b, result;
  logic [3:0]  n, z, v, c;

  int total = 0;
  int bad   = 0;

  vector_alu #(.WIDTH(16), .LANES(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .n(n), .z(z), .v(v), .c(c)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [3:0]  n;
    logic [3:0]  z;
    logic [3:0]  v;
    logic [3:0]  c;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int j);
    logic [15:0] t;
    t = 16'h0A00 + 16'(j);
    return {t, t, t, t};
  endfunction

  logic [63:0] sa, sb;
  logic [63:0] sexp [5];
  int idx, got, gaps, seen;
  logic acc, take;

  initial begin
    // lanes packed {lane3, lane2, lane1, lane0}
    tbl[0] = '{3'b000, 64'h0000_0001_FFFF_7FFF, 64'h0000_0001_0001_0001,
               64'h0000_0002_0000_8000, 4'b0001, 4'b1010, 4'b0001, 4'b0010};
    tbl[1] = '{3'b001, 64'h8000_0000_0003_0005, 64'h0001_0001_0005_0005,
               64'h7FFF_FFFF_FFFE_0000, 4'b0110, 4'b0001, 4'b1000, 4'b1001};
    tbl[2] = '{3'b010, 64'hF0F0_FFFF_1234_0000, 64'h0FF0_00FF_FF00_FFFF,
               64'h00F0_00FF_1200_0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    tbl[3] = '{3'b011, 64'hF0F0_FFFF_1234_0000, 64'h0FF0_00FF_FF00_FFFF,
               64'hFFF0_FFFF_FF34_FFFF, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[4] = '{3'b100, 64'hF0F0_FFFF_1234_0000, 64'h0FF0_00FF_FF00_FFFF,
               64'hFF00_FF00_ED34_FFFF, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[5] = '{3'b101, 64'h0004_0003_0002_FFFF, 64'h1111_2222_3333_4444,
               64'h0000_0000_0000_0008, 4'b0000, 4'b1110, 4'b0000, 4'b0000};
    tbl[6] = '{3'b110, 64'h8000_0000_0001_7FFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0001_7FFF, 4'b1000, 4'b0100, 4'b0000, 4'b0000};
    tbl[7] = '{3'b111, 64'h1234_1234_1234_1234, 64'h0000_8001_0000_0000,
               64'h0000_8001_0000_0000, 4'b0100, 4'b1011, 4'b0000, 4'b0000};
    tbl[8] = '{3'b000, 64'h1234_4000_FFFF_8000, 64'h1111_4000_FFFF_8000,
               64'h2345_8000_FFFE_0000, 4'b0110, 4'b0001, 4'b0101, 4'b0011};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst result", result, 64'd0);
    chk("rst z", 64'(z), 64'hF);
    chk("rst nvc", {52'd0, n, v, c}, 64'd0);
    rst = 1'b0;
    #1 chk("rst in_ready", 64'(in_ready), 64'd1);

    // single-bundle table vectors
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      op = tbl[i].op; a = tbl[i].a; b = tbl[i].b; in_valid = 1'b1;
      #1 chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d early", i), 64'(out_valid), 64'd0);
      @(negedge clk);
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d result", i), result, tbl[i].res);
      chk($sformatf("vec%0d nzvc", i), {48'd0, n, z, v, c},
          {48'd0, tbl[i].n, tbl[i].z, tbl[i].v, tbl[i].c});
    end
    @(negedge clk);
    chk("idle out_valid", 64'(out_valid), 64'd0);

    // back-pressure: five bundles, consumer stalled
    out_ready = 1'b0; op = 3'b110; b = '0; idx = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      in_valid = (idx < 5); a = mk(idx);
      #1 acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    #1;
    chk("bp accepted", 64'(idx), 64'd2);
    chk("bp in_ready", 64'(in_ready), 64'd0);
    chk("bp hold valid", 64'(out_valid), 64'd1);
    chk("bp hold result", result, mk(0));
    out_ready = 1'b1; got = 0; gaps = 0;
    for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
      if (cyc > 0) @(negedge clk);
      in_valid = (idx < 5); a = mk(idx);
      #1;
      acc  = in_valid && in_ready;
      take = out_valid && out_ready;
      if (take) begin
        chk($sformatf("bp out%0d", got), result, mk(got));
        got++;
      end else if (got > 0) begin
        gaps++;
      end
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp got", 64'(got), 64'd5);
    chk("bp gaps", 64'(gaps), 64'd0);
    chk("bp sent", 64'(idx), 64'd5);
    @(negedge clk);

    // streaming latency with consumer always ready
    sa = 64'hF0F0_FFFF_1234_0000; sb = 64'h0FF0_00FF_FF00_FFFF;
    sexp[0] = 64'h00F0_00FF_1200_0000;
    sexp[1] = 64'hFFF0_FFFF_FF34_FFFF;
    sexp[2] = 64'hFF00_FF00_ED34_FFFF;
    sexp[3] = sa;
    sexp[4] = sb;
    a = sa; b = sb;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = (i < 5);
      case (i)
        0: op = 3'b010;
        1: op = 3'b011;
        2: op = 3'b100;
        3: op = 3'b110;
        default: op = 3'b111;
      endcase
      #1;
      if (i < 5) chk($sformatf("st%0d in_ready", i), 64'(in_ready), 64'd1);
      if (i < 2 || i > 6) chk($sformatf("st%0d no out", i), 64'(out_valid), 64'd0);
      else begin
        chk($sformatf("st%0d out_valid", i), 64'(out_valid), 64'd1);
        chk($sformatf("st%0d result", i), result, sexp[i-2]);
      end
    end
    in_valid = 1'b0;

    // flush with two in flight and a third presented
    out_ready = 1'b0; op = 3'b110;
    @(negedge clk); a = mk(20); in_valid = 1'b1;
    @(negedge clk); a = mk(21);
    @(negedge clk); a = mk(22); flush = 1'b1;
    #1 chk("fl in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1; seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("fl none emerge", 64'(seen), 64'd0);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    @(negedge clk); a = mk(30); in_valid = 1'b1;
    @(negedge clk); a = mk(31);
    @(negedge clk); in_valid = 1'b0;
    chk("ar pre valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar out_valid", 64'(out_valid), 64'd0);
    chk("ar result", result, 64'd0);
    chk("ar z", 64'(z), 64'hF);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1 chk("ar in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("ar drained", 64'(seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
